// File: rtl/stats_pcie_tlp_accum_pkg.sv
// ----------------------------------------------------------------------------
// stats_pcie_tlp_accum_pkg
// Shared constants for the TLP statistics accumulator: counter indices, the
// number of counters and the byte address of each counter on the read port.
// ----------------------------------------------------------------------------
package stats_pcie_tlp_accum_pkg;

    localparam int NUM_COUNTERS = 14;
    localparam int NUM_EVENTS   = 10;

    localparam int IDX_MEM_RD     = 0;
    localparam int IDX_MEM_WR     = 1;
    localparam int IDX_IO         = 2;
    localparam int IDX_CFG        = 3;
    localparam int IDX_MSG        = 4;
    localparam int IDX_CPL        = 5;
    localparam int IDX_CPL_UR     = 6;
    localparam int IDX_CPL_CA     = 7;
    localparam int IDX_ATOMIC     = 8;
    localparam int IDX_EP         = 9;
    localparam int IDX_HDR_DW     = 10;
    localparam int IDX_REQ_DW     = 11;
    localparam int IDX_PAYLOAD_DW = 12;
    localparam int IDX_CPL_DW     = 13;
    localparam int IDX_OVF        = 14;

    localparam int HDR_DW_WIDTH = 3;
    localparam int DW_WIDTH     = 11;

    // Byte address of a word index on the read port.
    function automatic int counter_addr(input int idx);
        return idx * 4;
    endfunction

endpackage

// File: rtl/stats_pcie_tlp_accum_counter_cell.sv
// ----------------------------------------------------------------------------
// stats_counter_cell
// One live counter with its shadow copy and sticky overflow flag.
//   clk, rst     : clock, synchronous active-high reset
//   i_inc        : registered increment applied this cycle (zero-extended)
//   i_snapshot   : copy live into shadow at this edge
//   o_shadow     : shadow counter value
//   o_overflow   : sticky carry-out flag of the live counter
// ----------------------------------------------------------------------------
module stats_counter_cell
    import stats_pcie_tlp_accum_pkg::*;
#(
    parameter int INC_WIDTH         = 1,
    parameter int COUNT_WIDTH       = 32,
    parameter int SATURATE          = 0,
    parameter int CLEAR_ON_SNAPSHOT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INC_WIDTH-1:0]   i_inc,
    input  logic                   i_snapshot,
    output logic [COUNT_WIDTH-1:0] o_shadow,
    output logic                   o_overflow
);

    logic [COUNT_WIDTH-1:0] r_live;
    logic [COUNT_WIDTH-1:0] r_shadow;
    logic                   r_overflow;

    logic [COUNT_WIDTH:0]   w_sum;
    logic                   w_carry;
    logic [COUNT_WIDTH-1:0] w_next_live;
    logic [COUNT_WIDTH-1:0] w_fresh;

    // One extra bit so the carry-out is visible.
    assign w_sum   = {1'b0, r_live} + {{(COUNT_WIDTH+1-INC_WIDTH){1'b0}}, i_inc};
    assign w_carry = w_sum[COUNT_WIDTH];

    assign w_next_live = (w_carry && (SATURATE != 0)) ? {COUNT_WIDTH{1'b1}}
                                                       : w_sum[COUNT_WIDTH-1:0];

    // Value of a freshly cleared counter that still absorbs this edge's
    // increment, so nothing is lost across a clearing snapshot.
    assign w_fresh = {{(COUNT_WIDTH-INC_WIDTH){1'b0}}, i_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_live     <= '0;
            r_shadow   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (i_snapshot) begin
                r_shadow <= r_live;
            end
            if (i_snapshot && (CLEAR_ON_SNAPSHOT != 0)) begin
                // The add from zero can never carry (increment is narrower
                // than the counter), so the flag restarts clear.
                r_live     <= w_fresh;
                r_overflow <= 1'b0;
            end else begin
                r_live     <= w_next_live;
                r_overflow <= r_overflow | w_carry;
            end
        end
    end

    assign o_shadow   = r_shadow;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/stats_pcie_tlp_accum.sv
// ----------------------------------------------------------------------------
// stats_pcie_tlp_accum
// Accumulates per-TLP statistics into 10 event and 4 DW-sum counters, copies
// them atomically into a shadow bank on snapshot, and serves the shadow bank
// through a single-cycle register read port.
//   clk, rst            : clock, synchronous active-high reset
//   stat_tlp_*          : event pulses (idx 0..9) and DW increments (10..13)
//   snapshot            : capture live counters into the shadow bank
//   snapshot_done       : one-cycle pulse after the capture edge
//   reg_rd_addr/en      : byte address and read strobe
//   reg_rd_data/ack     : read data (held between reads) and 1-cycle ack
//   overflow            : sticky per-counter overflow flags of the live bank
// Read map: word 0..13 shadow counters, 14 overflow flags, others read 0.
// ----------------------------------------------------------------------------
module stats_pcie_tlp_accum
    import stats_pcie_tlp_accum_pkg::*;
#(
    parameter int COUNT_WIDTH       = 32,
    parameter int SATURATE          = 0,
    parameter int CLEAR_ON_SNAPSHOT = 1,
    parameter int REG_ADDR_WIDTH    = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stat_tlp_mem_rd,
    input  logic                      stat_tlp_mem_wr,
    input  logic                      stat_tlp_io,
    input  logic                      stat_tlp_cfg,
    input  logic                      stat_tlp_msg,
    input  logic                      stat_tlp_cpl,
    input  logic                      stat_tlp_cpl_ur,
    input  logic                      stat_tlp_cpl_ca,
    input  logic                      stat_tlp_atomic,
    input  logic                      stat_tlp_ep,
    input  logic [HDR_DW_WIDTH-1:0]   stat_tlp_hdr_dw,
    input  logic [DW_WIDTH-1:0]       stat_tlp_req_dw,
    input  logic [DW_WIDTH-1:0]       stat_tlp_payload_dw,
    input  logic [DW_WIDTH-1:0]       stat_tlp_cpl_dw,
    input  logic                      snapshot,
    output logic                      snapshot_done,
    input  logic [REG_ADDR_WIDTH-1:0] reg_rd_addr,
    input  logic                      reg_rd_en,
    output logic [COUNT_WIDTH-1:0]    reg_rd_data,
    output logic                      reg_rd_ack,
    output logic [NUM_COUNTERS-1:0]   overflow
);

    localparam int IDXW     = REG_ADDR_WIDTH - 2;
    localparam int OVF_BITS = (COUNT_WIDTH < NUM_COUNTERS) ? COUNT_WIDTH : NUM_COUNTERS;

    // Registered increments: one cycle of input latency.
    logic [NUM_EVENTS-1:0]   r_ev;
    logic [HDR_DW_WIDTH-1:0] r_hdr_dw;
    logic [DW_WIDTH-1:0]     r_req_dw;
    logic [DW_WIDTH-1:0]     r_payload_dw;
    logic [DW_WIDTH-1:0]     r_cpl_dw;

    logic                    r_snapshot_done;
    logic                    r_rd_ack;
    logic [COUNT_WIDTH-1:0]  r_rd_data;

    logic [COUNT_WIDTH-1:0]  w_shadow [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] w_overflow;
    logic [IDXW-1:0]         w_idx;
    logic [3:0]              w_sel;
    logic                    w_idx_hi_zero;
    logic [COUNT_WIDTH-1:0]  w_rd_mux;
    logic [1:0]              w_unused_addr_lsbs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ev         <= '0;
            r_hdr_dw     <= '0;
            r_req_dw     <= '0;
            r_payload_dw <= '0;
            r_cpl_dw     <= '0;
        end else begin
            r_ev         <= {stat_tlp_ep, stat_tlp_atomic, stat_tlp_cpl_ca,
                             stat_tlp_cpl_ur, stat_tlp_cpl, stat_tlp_msg,
                             stat_tlp_cfg, stat_tlp_io, stat_tlp_mem_wr,
                             stat_tlp_mem_rd};
            r_hdr_dw     <= stat_tlp_hdr_dw;
            r_req_dw     <= stat_tlp_req_dw;
            r_payload_dw <= stat_tlp_payload_dw;
            r_cpl_dw     <= stat_tlp_cpl_dw;
        end
    end

    for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_event
        stats_counter_cell #(
            .INC_WIDTH(1), .COUNT_WIDTH(COUNT_WIDTH),
            .SATURATE(SATURATE), .CLEAR_ON_SNAPSHOT(CLEAR_ON_SNAPSHOT)
        ) u_cell (
            .clk(clk), .rst(rst), .i_inc(r_ev[g]), .i_snapshot(snapshot),
            .o_shadow(w_shadow[g]), .o_overflow(w_overflow[g])
        );
    end

    stats_counter_cell #(
        .INC_WIDTH(HDR_DW_WIDTH), .COUNT_WIDTH(COUNT_WIDTH),
        .SATURATE(SATURATE), .CLEAR_ON_SNAPSHOT(CLEAR_ON_SNAPSHOT)
    ) u_hdr_dw (
        .clk(clk), .rst(rst), .i_inc(r_hdr_dw), .i_snapshot(snapshot),
        .o_shadow(w_shadow[IDX_HDR_DW]), .o_overflow(w_overflow[IDX_HDR_DW])
    );

    stats_counter_cell #(
        .INC_WIDTH(DW_WIDTH), .COUNT_WIDTH(COUNT_WIDTH),
        .SATURATE(SATURATE), .CLEAR_ON_SNAPSHOT(CLEAR_ON_SNAPSHOT)
    ) u_req_dw (
        .clk(clk), .rst(rst), .i_inc(r_req_dw), .i_snapshot(snapshot),
        .o_shadow(w_shadow[IDX_REQ_DW]), .o_overflow(w_overflow[IDX_REQ_DW])
    );

    stats_counter_cell #(
        .INC_WIDTH(DW_WIDTH), .COUNT_WIDTH(COUNT_WIDTH),
        .SATURATE(SATURATE), .CLEAR_ON_SNAPSHOT(CLEAR_ON_SNAPSHOT)
    ) u_payload_dw (
        .clk(clk), .rst(rst), .i_inc(r_payload_dw), .i_snapshot(snapshot),
        .o_shadow(w_shadow[IDX_PAYLOAD_DW]), .o_overflow(w_overflow[IDX_PAYLOAD_DW])
    );

    stats_counter_cell #(
        .INC_WIDTH(DW_WIDTH), .COUNT_WIDTH(COUNT_WIDTH),
        .SATURATE(SATURATE), .CLEAR_ON_SNAPSHOT(CLEAR_ON_SNAPSHOT)
    ) u_cpl_dw (
        .clk(clk), .rst(rst), .i_inc(r_cpl_dw), .i_snapshot(snapshot),
        .o_shadow(w_shadow[IDX_CPL_DW]), .o_overflow(w_overflow[IDX_CPL_DW])
    );

    // Word index; byte-lane bits are ignored.
    assign w_idx              = reg_rd_addr[REG_ADDR_WIDTH-1:2];
    assign w_unused_addr_lsbs = reg_rd_addr[1:0];
    assign w_sel              = w_idx[3:0];

    if (IDXW > 4) begin : g_wide_idx
        assign w_idx_hi_zero = ~|w_idx[IDXW-1:4];
    end else begin : g_narrow_idx
        assign w_idx_hi_zero = 1'b1;
    end

    // Mux sees the shadow bank before this edge's update, so a read that
    // coincides with a snapshot returns the previous shadow value.
    always_comb begin
        w_rd_mux = '0;
        if (w_idx_hi_zero) begin
            if (w_sel < 4'(NUM_COUNTERS)) begin
                w_rd_mux = w_shadow[w_sel];
            end else if (w_sel == 4'(IDX_OVF)) begin
                w_rd_mux[OVF_BITS-1:0] = w_overflow[OVF_BITS-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_snapshot_done <= 1'b0;
            r_rd_ack        <= 1'b0;
            r_rd_data       <= '0;
        end else begin
            r_snapshot_done <= snapshot;
            r_rd_ack        <= reg_rd_en;
            if (reg_rd_en) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    assign snapshot_done = r_snapshot_done;
    assign reg_rd_ack    = r_rd_ack;
    assign reg_rd_data   = r_rd_data;
    assign overflow      = w_overflow;

endmodule

// File: tb/tb_stats_pcie_tlp_accum.sv
module tb_stats_pcie_tlp_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd, mem_wr, io, cfg, msg, cpl, cpl_ur, cpl_ca, atomic, ep;
    logic [2:0]  hdr_dw;
    logic [10:0] req_dw, payload_dw, cpl_dw;
    logic        snapshot;
    logic [5:0]  rd_addr;
    logic        rd_en;

    // m: default (32-bit, wrap, clear); s: 12-bit saturate; w: 12-bit wrap;
    // n: 32-bit, no clear on snapshot. All share the same stimulus.
    logic        m_done, s_done, w_done, n_done;
    logic        m_ack, s_ack, w_ack, n_ack;
    logic [31:0] m_data, n_data;
    logic [11:0] s_data, w_data;
    logic [13:0] m_ovf, s_ovf, w_ovf, n_ovf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stats_pcie_tlp_accum #(.COUNT_WIDTH(32), .SATURATE(0), .CLEAR_ON_SNAPSHOT(1), .REG_ADDR_WIDTH(6)) u_m (
        .clk(clk), .rst(rst), .stat_tlp_mem_rd(mem_rd), .stat_tlp_mem_wr(mem_wr),
        .stat_tlp_io(io), .stat_tlp_cfg(cfg), .stat_tlp_msg(msg), .stat_tlp_cpl(cpl),
        .stat_tlp_cpl_ur(cpl_ur), .stat_tlp_cpl_ca(cpl_ca), .stat_tlp_atomic(atomic),
        .stat_tlp_ep(ep), .stat_tlp_hdr_dw(hdr_dw), .stat_tlp_req_dw(req_dw),
        .stat_tlp_payload_dw(payload_dw), .stat_tlp_cpl_dw(cpl_dw), .snapshot(snapshot),
        .snapshot_done(m_done), .reg_rd_addr(rd_addr), .reg_rd_en(rd_en),
        .reg_rd_data(m_data), .reg_rd_ack(m_ack), .overflow(m_ovf));

    stats_pcie_tlp_accum #(.COUNT_WIDTH(12), .SATURATE(1), .CLEAR_ON_SNAPSHOT(1), .REG_ADDR_WIDTH(6)) u_s (
        .clk(clk), .rst(rst), .stat_tlp_mem_rd(mem_rd), .stat_tlp_mem_wr(mem_wr),
        .stat_tlp_io(io), .stat_tlp_cfg(cfg), .stat_tlp_msg(msg), .stat_tlp_cpl(cpl),
        .stat_tlp_cpl_ur(cpl_ur), .stat_tlp_cpl_ca(cpl_ca), .stat_tlp_atomic(atomic),
        .stat_tlp_ep(ep), .stat_tlp_hdr_dw(hdr_dw), .stat_tlp_req_dw(req_dw),
        .stat_tlp_payload_dw(payload_dw), .stat_tlp_cpl_dw(cpl_dw), .snapshot(snapshot),
        .snapshot_done(s_done), .reg_rd_addr(rd_addr), .reg_rd_en(rd_en),
        .reg_rd_data(s_data), .reg_rd_ack(s_ack), .overflow(s_ovf));

    stats_pcie_tlp_accum #(.COUNT_WIDTH(12), .SATURATE(0), .CLEAR_ON_SNAPSHOT(1), .REG_ADDR_WIDTH(6)) u_w (
        .clk(clk), .rst(rst), .stat_tlp_mem_rd(mem_rd), .stat_tlp_mem_wr(mem_wr),
        .stat_tlp_io(io), .stat_tlp_cfg(cfg), .stat_tlp_msg(msg), .stat_tlp_cpl(cpl),
        .stat_tlp_cpl_ur(cpl_ur), .stat_tlp_cpl_ca(cpl_ca), .stat_tlp_atomic(atomic),
        .stat_tlp_ep(ep), .stat_tlp_hdr_dw(hdr_dw), .stat_tlp_req_dw(req_dw),
        .stat_tlp_payload_dw(payload_dw), .stat_tlp_cpl_dw(cpl_dw), .snapshot(snapshot),
        .snapshot_done(w_done), .reg_rd_addr(rd_addr), .reg_rd_en(rd_en),
        .reg_rd_data(w_data), .reg_rd_ack(w_ack), .overflow(w_ovf));

    stats_pcie_tlp_accum #(.COUNT_WIDTH(32), .SATURATE(0), .CLEAR_ON_SNAPSHOT(0), .REG_ADDR_WIDTH(6)) u_n (
        .clk(clk), .rst(rst), .stat_tlp_mem_rd(mem_rd), .stat_tlp_mem_wr(mem_wr),
        .stat_tlp_io(io), .stat_tlp_cfg(cfg), .stat_tlp_msg(msg), .stat_tlp_cpl(cpl),
        .stat_tlp_cpl_ur(cpl_ur), .stat_tlp_cpl_ca(cpl_ca), .stat_tlp_atomic(atomic),
        .stat_tlp_ep(ep), .stat_tlp_hdr_dw(hdr_dw), .stat_tlp_req_dw(req_dw),
        .stat_tlp_payload_dw(payload_dw), .stat_tlp_cpl_dw(cpl_dw), .snapshot(snapshot),
        .snapshot_done(n_done), .reg_rd_addr(rd_addr), .reg_rd_en(rd_en),
        .reg_rd_data(n_data), .reg_rd_ack(n_ack), .overflow(n_ovf));

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        {mem_rd, mem_wr, io, cfg, msg, cpl, cpl_ur, cpl_ca, atomic, ep} = '0;
        hdr_dw = '0; req_dw = '0; payload_dw = '0; cpl_dw = '0;
        snapshot = 1'b0; rd_en = 1'b0; rd_addr = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic take_snapshot();
        snapshot = 1'b1;
        tick();
        snapshot = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] addr);
        rd_addr = addr;
        rd_en   = 1'b1;
        tick();
        rd_en   = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (m_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %0d want 0", m_ack); end
        n_cmp++; if (m_data !== 32'd0) begin n_err++; $display("FAIL reset_data: got %0d want 0", m_data); end
        n_cmp++; if (m_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0d want 0", m_done); end
        n_cmp++; if (s_ovf !== 14'd0) begin n_err++; $display("FAIL reset_ovf: got %0h want 0", s_ovf); end
    endtask

    task automatic test_increment_read();
        apply_reset();
        mem_rd = 1'b1; req_dw = 11'd128;
        tick(3);
        req_dw = 11'd0;
        tick(2);
        mem_rd = 1'b0;
        tick(3);
        take_snapshot();
        n_cmp++; if (m_done !== 1'b1) begin n_err++; $display("FAIL snap_done_pulse: got %0d want 1", m_done); end
        do_read(6'h04);
        n_cmp++; if (m_done !== 1'b0) begin n_err++; $display("FAIL snap_done_width: got %0d want 0", m_done); end
        n_cmp++; if (m_ack !== 1'b1) begin n_err++; $display("FAIL rd_ack_mem_wr: got %0d want 1", m_ack); end
        n_cmp++; if (m_data !== 32'd0) begin n_err++; $display("FAIL rd_mem_wr: got %0d want 0", m_data); end
        do_read(6'h00);
        n_cmp++; if (m_data !== 32'd5) begin n_err++; $display("FAIL rd_mem_rd: got %0d want 5", m_data); end
        do_read(6'h2C);
        n_cmp++; if (m_data !== 32'd384) begin n_err++; $display("FAIL rd_req_dw: got %0d want 384", m_data); end
        tick();
        n_cmp++; if (m_ack !== 1'b0) begin n_err++; $display("FAIL rd_ack_width: got %0d want 0", m_ack); end
        n_cmp++; if (m_data !== 32'd384) begin n_err++; $display("FAIL rd_data_hold: got %0d want 384", m_data); end
    endtask

    task automatic test_dw_boundary();
        apply_reset();
        payload_dw = 11'd1024;
        tick(4);
        take_snapshot();
        do_read(6'h30);
        n_cmp++; if (m_data !== 32'd3072) begin n_err++; $display("FAIL dw_snap1: got %0d want 3072", m_data); end
        tick(8);
        take_snapshot();
        payload_dw = 11'd0;
        do_read(6'h30);
        n_cmp++; if (m_data !== 32'd10240) begin n_err++; $display("FAIL dw_snap2: got %0d want 10240", m_data); end
        tick(2);
        take_snapshot();
        do_read(6'h30);
        n_cmp++; if (m_data !== 32'd2048) begin n_err++; $display("FAIL dw_remainder: got %0d want 2048", m_data); end
    endtask

    task automatic test_saturate_wrap();
        apply_reset();
        cpl_dw = 11'd1024;
        tick(5);
        cpl_dw = 11'd0;
        tick(2);
        n_cmp++; if (s_ovf[13] !== 1'b1) begin n_err++; $display("FAIL sat_ovf_set: got %0d want 1", s_ovf[13]); end
        n_cmp++; if (w_ovf[13] !== 1'b1) begin n_err++; $display("FAIL wrap_ovf_set: got %0d want 1", w_ovf[13]); end
        n_cmp++; if (m_ovf !== 14'd0) begin n_err++; $display("FAIL wide_no_ovf: got %0h want 0", m_ovf); end
        take_snapshot();
        n_cmp++; if (s_ovf[13] !== 1'b0) begin n_err++; $display("FAIL sat_ovf_clear: got %0d want 0", s_ovf[13]); end
        do_read(6'h34);
        n_cmp++; if (s_data !== 12'd4095) begin n_err++; $display("FAIL sat_value: got %0d want 4095", s_data); end
        n_cmp++; if (w_data !== 12'd1024) begin n_err++; $display("FAIL wrap_value: got %0d want 1024", w_data); end
        n_cmp++; if (m_data !== 32'd5120) begin n_err++; $display("FAIL wide_value: got %0d want 5120", m_data); end
        take_snapshot();
        do_read(6'h38);
        n_cmp++; if (s_data !== 12'd0) begin n_err++; $display("FAIL sat_ovf_read: got %0h want 0", s_data); end
        n_cmp++; if (w_data !== 12'd0) begin n_err++; $display("FAIL wrap_ovf_read: got %0h want 0", w_data); end
    endtask

    task automatic test_no_clear();
        apply_reset();
        ep = 1'b1;
        tick(7);
        ep = 1'b0;
        tick(2);
        take_snapshot();
        do_read(6'h24);
        n_cmp++; if (n_data !== 32'd7) begin n_err++; $display("FAIL noclr_snap1: got %0d want 7", n_data); end
        ep = 1'b1;
        tick(2);
        ep = 1'b0;
        tick(2);
        take_snapshot();
        do_read(6'h24);
        n_cmp++; if (n_data !== 32'd9) begin n_err++; $display("FAIL noclr_snap2: got %0d want 9", n_data); end
        n_cmp++; if (m_data !== 32'd2) begin n_err++; $display("FAIL clr_snap2: got %0d want 2", m_data); end
    endtask

    task automatic test_collision_range();
        apply_reset();
        mem_rd = 1'b1;
        tick(3);
        mem_rd = 1'b0;
        tick(2);
        take_snapshot();
        mem_rd = 1'b1;
        tick(2);
        mem_rd = 1'b0;
        tick(2);
        snapshot = 1'b1;
        do_read(6'h00);
        snapshot = 1'b0;
        n_cmp++; if (m_data !== 32'd3) begin n_err++; $display("FAIL collide_old: got %0d want 3", m_data); end
        n_cmp++; if (m_done !== 1'b1) begin n_err++; $display("FAIL collide_done: got %0d want 1", m_done); end
        do_read(6'h00);
        n_cmp++; if (m_data !== 32'd2) begin n_err++; $display("FAIL collide_new: got %0d want 2", m_data); end
        do_read(6'h3C);
        n_cmp++; if (m_ack !== 1'b1) begin n_err++; $display("FAIL range_ack: got %0d want 1", m_ack); end
        n_cmp++; if (m_data !== 32'd0) begin n_err++; $display("FAIL range_data: got %0d want 0", m_data); end
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        mem_rd = 1'b1; cpl_dw = 11'd1024;
        tick(6);
        n_cmp++; if (s_ovf[13] !== 1'b1) begin n_err++; $display("FAIL mid_ovf_pre: got %0d want 1", s_ovf[13]); end
        take_snapshot();
        tick(2);
        rst = 1'b1; snapshot = 1'b1; rd_en = 1'b1; rd_addr = 6'h00;
        tick();
        n_cmp++; if (m_ack !== 1'b0) begin n_err++; $display("FAIL mid_no_ack: got %0d want 0", m_ack); end
        n_cmp++; if (m_done !== 1'b0) begin n_err++; $display("FAIL mid_no_done: got %0d want 0", m_done); end
        rst = 1'b0;
        idle_inputs();
        tick();
        do_read(6'h00);
        n_cmp++; if (m_data !== 32'd0) begin n_err++; $display("FAIL mid_shadow0: got %0d want 0", m_data); end
        do_read(6'h34);
        n_cmp++; if (s_data !== 12'd0) begin n_err++; $display("FAIL mid_shadow13: got %0d want 0", s_data); end
        do_read(6'h38);
        n_cmp++; if (s_data !== 12'd0) begin n_err++; $display("FAIL mid_ovf_read: got %0h want 0", s_data); end
        take_snapshot();
        do_read(6'h00);
        n_cmp++; if (m_data !== 32'd0) begin n_err++; $display("FAIL mid_live0: got %0d want 0", m_data); end
        do_read(6'h34);
        n_cmp++; if (m_data !== 32'd0) begin n_err++; $display("FAIL mid_live13: got %0d want 0", m_data); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_increment_read();
        test_dw_boundary();
        test_saturate_wrap();
        test_no_clear();
        test_collision_range();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stats_pcie_tlp_accum.md
Name: stats_pcie_tlp_accum

Overview:
Downstream consumer of the per-TLP statistics pulse and count outputs produced by the PCIe TLP stats stage. Accumulates 10 event counters and 4 DW-sum counters in live registers. On a snapshot request, atomically copies all live counters into a shadow bank. Host software reads the shadow bank through a simple single-cycle register read port.

Parameters:
COUNT_WIDTH, 32, width of each live and shadow counter (min 12, max 64)
SATURATE, 0, 1 = counters saturate at all-ones; 0 = counters wrap modulo 2^COUNT_WIDTH
CLEAR_ON_SNAPSHOT, 1, 1 = live counters clear when a snapshot is taken; 0 = live counters keep running
REG_ADDR_WIDTH, 6, byte address width of the read port

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
stat_tlp_mem_rd  in  1  event pulse, counter index 0
stat_tlp_mem_wr  in  1  event pulse, index 1
stat_tlp_io  in  1  event pulse, index 2
stat_tlp_cfg  in  1  event pulse, index 3
stat_tlp_msg  in  1  event pulse, index 4
stat_tlp_cpl  in  1  event pulse, index 5
stat_tlp_cpl_ur  in  1  event pulse, index 6
stat_tlp_cpl_ca  in  1  event pulse, index 7
stat_tlp_atomic  in  1  event pulse, index 8
stat_tlp_ep  in  1  event pulse, index 9
stat_tlp_hdr_dw  in  3  header DW increment, index 10
stat_tlp_req_dw  in  11  request DW increment, index 11
stat_tlp_payload_dw  in  11  payload DW increment, index 12
stat_tlp_cpl_dw  in  11  completion DW increment, index 13
snapshot  in  1  pulse: capture live counters into the shadow bank
snapshot_done  out  1  one-cycle pulse one cycle after the capture
reg_rd_addr  in  REG_ADDR_WIDTH  byte address; word index = reg_rd_addr[REG_ADDR_WIDTH-1:2]
reg_rd_en  in  1  read strobe
reg_rd_data  out  COUNT_WIDTH  shadow counter value
reg_rd_ack  out  1  read completion pulse
overflow  out  14  sticky per-counter overflow/saturation flags (live bank)

Behaviour:
- Reset (rst high at a clk edge): all live counters, shadow counters and overflow flags go to 0; snapshot_done=0, reg_rd_ack=0, reg_rd_data=0. Reset takes priority over every other event. A read or snapshot presented in the same cycle as reset is dropped and gets no ack or done pulse.
- Inputs are registered internally: the increment applied at edge N+1 is the input value sampled at edge N. This gives 1 cycle of input latency, so a live counter reflects an input 2 edges after it is presented.
- Each cycle, live[i] <= live[i] + inc_r[i]:
  - Event counters add 0 or 1.
  - DW counters add the zero-extended value (0..1024; hdr 0..4).
  - The sum is computed at COUNT_WIDTH+1 bits. The carry-out sets overflow[i], which stays set until a snapshot with CLEAR_ON_SNAPSHOT=1 or until reset.
  - SATURATE=1: on carry-out the live counter takes all-ones and holds there.
  - SATURATE=0: the live counter takes the low COUNT_WIDTH bits of the sum.
- Snapshot, when snapshot is sampled high at edge N:
  - At edge N, shadow[i] <= live[i] (value before this edge's increment).
  - CLEAR_ON_SNAPSHOT=1: at the same edge, live[i] <= inc_r[i] and overflow[i] <= carry of this edge's add only. No increment is lost or double-counted.
  - CLEAR_ON_SNAPSHOT=0: live counters continue normally and overflow flags are unaffected.
  - snapshot_done is high for exactly one cycle after edge N.
  - Back-to-back snapshot pulses each take effect. Snapshot held high snapshots every cycle.
- Read port:
  - When reg_rd_en is sampled at edge N, reg_rd_ack=1 and reg_rd_data=shadow[index] are presented after edge N, for one cycle.
  - Index 14..15 (beyond 13, up to 0x3C): data = overflow flags, zero-extended, at index 14; data = 0 at index 15.
  - Any index above 15: data = 0, ack still asserted.
  - Reads are accepted every cycle with no stall.
  - reg_rd_data holds its last value when ack=0.
  - A read and a snapshot at the same edge returns the OLD shadow value.
- Shadow counters change only on snapshot or reset.

Decomposition:
- Shared package: counter index constants (IDX_MEM_RD=0 .. IDX_CPL_DW=13, IDX_OVF=14), NUM_COUNTERS=14, byte address map (index*4).
- One sub-module, stats_counter_cell: a single live+shadow+overflow counter with parameters INC_WIDTH, COUNT_WIDTH, SATURATE and CLEAR_ON_SNAPSHOT. It is instantiated 14 times via generate, with INC_WIDTH 1/3/11.
- The top level handles input registration, the read mux and snapshot_done.

Test Plan:
- Reset value, increment, snapshot, read:
  - Stimulus: after reset, pulse stat_tlp_mem_rd 5 cycles and stat_tlp_req_dw=128 on 3 of those cycles; wait 3 cycles; snapshot; read 0x00 and 0x2C.
  - Response: reg_rd_data 5 then 384, each with a 1-cycle ack. Reading 0x04 returns 0.
- DW boundary and simultaneous snapshot:
  - Stimulus: stat_tlp_payload_dw=1024 continuously; snapshot on the cycle its 4th registered increment applies; snapshot again 10 cycles later.
  - Response: first shadow[12]=3072, second=10240; the totals account for every increment with none lost.
- Saturate/wrap:
  - Stimulus: COUNT_WIDTH=12; cpl_dw=1024 for 5 cycles.
  - Response with SATURATE=1: live 4095 and overflow[13]=1.
  - Response with SATURATE=0: live 1024 (5120 mod 4096) and overflow[13]=1.
  - A following snapshot (CLEAR_ON_SNAPSHOT=1) with idle inputs clears overflow[13]; a read of 0x38 after the second snapshot returns 0.
- CLEAR_ON_SNAPSHOT=0:
  - Stimulus: 7 stat_tlp_ep pulses, snapshot, 2 more pulses, snapshot.
  - Response: shadow[9] reads 7 then 9.
- Read/snapshot collision and out-of-range:
  - Stimulus: read 0x00 on the same edge as a snapshot.
  - Response: old shadow value returned. Address 0x3C returns 0 with ack.
- Reset mid-operation:
  - Stimulus: rst asserted during continuous increments plus a pending read.
  - Response: no ack; all counters, shadows and overflow are 0 on the next read after rst deasserts.
